// File: rtl/wallace_mac5_stream_if.sv
// Operand/result stream bundle for wallace_mac5_stream.
// master = operand source plus result consumer, slave = the accumulator block.
interface wallace_mac5_stream_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_x;
  logic [4:0]       in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_x, in_y, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_y, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/wallace_mac5_stream.sv
// Streaming saturating dot-product accumulator over 5-bit unsigned operand
// pairs, built around a combinational 5x5 Wallace-tree multiplier.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting operand pairs; in_last moves on to DRAIN
// DRAIN | input closed, waiting for the last term to leave S2
// DONE  | frame result presented, held until out_ready

// 5x5 unsigned multiplier: five partial-product rows reduced by three
// carry-save layers to two rows, then a single carry-propagate add.
module WallaceMul5x5 (
  input  logic [4:0] x,
  input  logic [4:0] y,
  output logic [9:0] p
);
  logic [9:0] r0, r1, r2, r3, r4;
  logic [9:0] s1, c1, s2, c2, s3, c3;

  assign r0 = {5'b0, x & {5{y[0]}}};
  assign r1 = {4'b0, x & {5{y[1]}}, 1'b0};
  assign r2 = {3'b0, x & {5{y[2]}}, 2'b0};
  assign r3 = {2'b0, x & {5{y[3]}}, 3'b0};
  assign r4 = {1'b0, x & {5{y[4]}}, 4'b0};

  // Layer 1: rows 0..2 compressed, rows 3 and 4 pass through.
  assign s1 = r0 ^ r1 ^ r2;
  assign c1 = {(r0[8:0] & r1[8:0]) | (r0[8:0] & r2[8:0]) | (r1[8:0] & r2[8:0]), 1'b0};
  // Layer 2: four rows down to three.
  assign s2 = s1 ^ c1 ^ r3;
  assign c2 = {(s1[8:0] & c1[8:0]) | (s1[8:0] & r3[8:0]) | (c1[8:0] & r3[8:0]), 1'b0};
  // Layer 3: three rows down to two; the product never exceeds 961 so
  // carries out of bit 9 are always zero.
  assign s3 = s2 ^ c2 ^ r4;
  assign c3 = {(s2[8:0] & c2[8:0]) | (s2[8:0] & r4[8:0]) | (c2[8:0] & r4[8:0]), 1'b0};

  assign p = s3 + c3;
endmodule

module wallace_mac5_stream #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  wallace_mac5_stream_if.slave bus
);
  typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_DONE} state_t;

  state_t state, state_next;

  logic             s1_valid, s1_last;
  logic [4:0]       s1_x, s1_y;
  logic             s2_valid, s2_last;
  logic [9:0]       s2_p;
  logic [9:0]       prod;
  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             ovf, ovf_next;
  logic             out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             in_accept, out_hs, last_term;

  WallaceMul5x5 u_mul (.x(s1_x), .y(s1_y), .p(prod));

  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.out_count = out_count;
  assign bus.out_ovf   = out_ovf;

  assign in_accept = bus.in_valid & (state == ST_ACC);
  assign out_hs    = (state == ST_DONE) & out_valid & bus.out_ready;
  assign last_term = s2_valid & s2_last;

  // Saturating add: one spare bit catches the wrap, which pins acc at max.
  assign acc_sum  = {1'b0, acc} + (ACC_W+1)'(s2_p);
  assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
  assign ovf_next = ovf | acc_sum[ACC_W];
  assign cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ACC;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:   if (in_accept && bus.in_last) state_next = ST_DRAIN;
      ST_DRAIN: if (last_term)                state_next = ST_DONE;
      ST_DONE:  if (out_hs)                   state_next = ST_ACC;
      default:                                state_next = ST_ACC;
    endcase
  end

  // Operand/product pipeline, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_p      <= '0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      s1_valid <= in_accept;
      if (in_accept) begin
        s1_x    <= bus.in_x;
        s1_y    <= bus.in_y;
        s1_last <= bus.in_last;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_p    <= prod;
        s2_last <= s1_last;
      end
      if (s2_valid) begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
      if (last_term) begin
        out_valid <= 1'b1;
        out_sum   <= acc_next;
        out_count <= cnt_next;
        out_ovf   <= ovf_next;
      end else if (out_hs) begin
        // Result registers keep the delivered frame until the next one loads.
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end
    end
  end
endmodule

// File: doc/wallace_mac5_stream.md
Name: wallace_mac5_stream

Overview:
- Streaming dot-product accumulator built around the existing combinational 5x5 Wallace multiplier (WallaceMul5x5, ports x, y, p).
- Accepts a frame of unsigned 5-bit operand pairs over a valid/ready handshake, ending with a pair marked last.
- Multiplies each pair, accumulates the products with saturation, and presents one result per frame on an output valid/ready handshake.
- Sits directly downstream of the operand source and consumes every product WallaceMul5x5 produces.

Parameters:
ACC_W, 16, accumulator/sum width in bits; legal range 10..32.
CNT_W, 8, term-counter width in bits; saturates at 2^CNT_W-1.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept a pair
in_x  in  5  unsigned multiplicand
in_y  in  5  unsigned multiplier
in_last  in  1  pair is the final term of the frame
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts result
out_sum  out  ACC_W  saturated sum of products
out_count  out  CNT_W  number of terms in frame (saturating)
out_ovf  out  1  sum saturated during this frame (sticky per frame)

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset:
  - State goes to ACC.
  - in_ready=1 (combinational from state), out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Accumulator, counter, overflow flag, and both pipeline valid bits are cleared.
  - Any in-flight terms are discarded, including when reset arrives mid-frame or while in DONE.
- Input accept: a pair is accepted when in_valid & in_ready are high at a rising edge. in_valid gaps (bubbles) are allowed anywhere in a frame.
- Pipeline for an accept at edge k:
  - S1 registers x, y, last and valid at edge k.
  - WallaceMul5x5 computes p (10 bits) combinationally from S1.
  - S2 registers p, last and valid at edge k+1.
  - The accumulator adds zero-extended p at edge k+2.
  - Throughput is one pair per cycle.
- Arithmetic:
  - acc_next = acc + p, computed at ACC_W+1 bits.
  - If bit ACC_W is set: acc = 2^ACC_W-1, ovf=1. Once saturated, acc stays at max for the rest of the frame.
  - Counter increments per accumulated term and saturates at 2^CNT_W-1.
- State machine:
  - ACC: in_ready=1. Accepting a pair with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0; waits until the last term leaves S2. On the edge that accumulates the S2 last term, out_sum/out_count/out_ovf are loaded with the final values (including that term) and out_valid is set; state moves to DONE. out_valid is therefore high two cycles after the edge that accepted in_last.
  - DONE: in_ready=0; outputs held stable while out_valid=1 & out_ready=0. On out_valid & out_ready at an edge: out_valid=0, accumulator/counter/ovf cleared to 0, state to ACC.
- Output registers retain the last delivered values after handshake until the next frame loads them.
- Boundary cases:
  - Single-term frame: in_last on the first pair is legal.
  - Pairs with in_valid high while in_ready=0 are ignored. The source must hold them; the block never accepts them.
  - out_ready high outside DONE has no effect.
  - A 0 operand contributes 0 but still counts as a term.

Test Plan:
- Frame (12,12),(15,5),(9,5,last) back-to-back -> out_valid 2 cycles after last accept; out_sum=264, out_count=3, out_ovf=0.
- Single term (31,31,last) with out_ready=1 -> out_sum=961, out_count=1; out_valid high exactly 1 cycle; in_ready returns 1 the next cycle.
- Frame (0,27),(7,7,last) with 2-cycle in_valid bubble between pairs -> out_sum=49, out_count=2.
- Backpressure: frame (10,10,last), out_ready held 0 for 5 cycles -> out_sum=100 stable, out_valid=1, in_ready=0 throughout; released after handshake.
- Overflow: 69 x (31,31), last on 69th, ACC_W=16 -> out_sum=65535, out_count=69, out_ovf=1. Next frame (1,1,last) -> out_sum=1, out_ovf=0.
- Reset mid-frame after accepting (30,20),(5,5) -> outputs 0, in_ready=1 next cycle. Following frame (2,3,last) -> out_sum=6, out_count=1.
